// File: rtl/round_robin_arbiter_if.sv
// rtl/round_robin_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface round_robin_arbiter_if #(
    parameter int n = 4
);
    logic [0:n-1]         r;
    logic [0:n-1]         g;
    logic                 busy;
    logic [$clog2(n)-1:0] gid;

    modport master (output r, input g, input busy, input gid);
    modport slave  (input r, output g, output busy, output gid);
endinterface

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - registered round-robin arbiter with bounded hold time
module round_robin_arbiter #(
    parameter int n       = 4,
    parameter int MAXHOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    round_robin_arbiter_if.slave bus
);
    localparam int PW = $clog2(n);
    localparam int CW = $clog2(MAXHOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [0:n-1]  g_q, g_d;
    logic [PW-1:0] gid_q, gid_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          found;
    logic [PW-1:0] sel;

    // Rotating priority search: first request at or after ptr, wrapping past n-1.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < n; k++) begin
            idx = (int'(ptr_q) + k) % n;
            if (!found && bus.r[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    // Next-state: grant from IDLE only, so every release is followed by one empty cycle.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = GRANT;
                    g_d      = '0;
                    g_d[sel] = 1'b1;
                    gid_d    = sel;
                    cnt_d    = CW'(1);
                end
            end
            GRANT: begin
                if (bus.r[gid_q] && (cnt_q < CW'(MAXHOLD))) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d = IDLE;
                    g_d     = '0;
                    gid_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = (gid_q == PW'(n - 1)) ? '0 : gid_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any grant immediately, independent of the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.g    = g_q;
    assign bus.busy = |g_q;
    assign bus.gid  = gid_q;
endmodule
